// File: rtl/rx_pingpong_ram.sv
// Double-buffered receive frame store: the writer fills one bank while the reader consumes the other.
// Optional feature macro: RX_DROP_CNT_EN adds a saturating dropped-frame counter on port drop_cnt.
module rx_pingpong_ram #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned IMG_WIDTH    = 80,
    parameter int unsigned IMG_HEIGHT   = 120,
    parameter int unsigned TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int unsigned ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
`ifdef RX_DROP_CNT_EN
    ,
    parameter int unsigned DROP_CNT_WIDTH = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic                  frame_done,
    output logic                  o_frame_done,
    output logic                  frame_ready,
    output logic                  frame_dropped,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  rd_valid,
    input  logic                  rd_release
`ifdef RX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_wb;
    logic [DATA_WIDTH-1:0] r_mem [2][TOTAL_PIXELS];

    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_rd_bank;

    // Address checks are done one bit wider so a power-of-two depth still compares correctly.
    assign w_wr_in_range = ({1'b0, wAddr} < (ADDR_WIDTH + 1)'(TOTAL_PIXELS));
    assign w_rd_in_range = ({1'b0, rAddr} < (ADDR_WIDTH + 1)'(TOTAL_PIXELS));
    assign w_rd_bank     = ~r_wb;
    assign frame_ready   = (r_state == S_READY);

    // Bank ownership FSM; a simultaneous release and frame_done hands the new frame over without a drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_EMPTY;
            r_wb          <= 1'b0;
            o_frame_done  <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            o_frame_done  <= 1'b0;
            frame_dropped <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    if (frame_done) begin
                        r_wb         <= ~r_wb;
                        o_frame_done <= 1'b1;
                        r_state      <= S_READY;
                    end
                end
                S_READY: begin
                    if (frame_done && rd_release) begin
                        r_wb         <= ~r_wb;
                        o_frame_done <= 1'b1;
                    end else if (frame_done) begin
                        frame_dropped <= 1'b1;
                    end else if (rd_release) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (we && w_wr_in_range) begin
            r_mem[r_wb][wAddr] <= wData;
        end
    end

    // Registered read port; out-of-range addresses return zero but still strobe valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rData    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_en && (r_state == S_READY)) begin
                rd_valid <= 1'b1;
                rData    <= w_rd_in_range ? r_mem[w_rd_bank][rAddr] : '0;
            end
        end
    end

`ifdef RX_DROP_CNT_EN
    // Saturating count of discarded frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (frame_dropped && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end
`endif

endmodule
